mdu_issue_ctrl: RTL and testbench
=================================

// Module: mdu_issue_ctrl
// PURPOSE
//  Owns HI/LO and shares one multiply/divide unit (MDU) between the EXE_up and EXE_down issue slots.
//  Accepts at most one op at a time and runs it without blocking the pipe.
//  Holds the result until the op commits, then writes HI/LO.
//  Drives nonBlockMark_o so EXE stages stall MFHI/MFLO while an op is in flight.
// PARAMETERS
//  MUL_STAGES  2   cycles from accept to product-ready for MULT/MULTU (>=1)
//  DIV_CYCLES  33  cycles from accept to result-ready for DIV/DIVU (1 setup + 32 iterations)
// PORTS
//  clk            in   1   single clock; all state on posedge
//  rst            in   1   reset; asynchronous, active-high
//  up_req_i       in   1   EXE_up slot presents an MDU op (older slot)
//  up_op_i        in   3   `MDU_OP: MULT, MULTU, DIV, DIVU, MTHI, MTLO
//  up_src0_i      in   32  rs value (forwarded)
//  up_src1_i      in   32  rt value (forwarded)
//  down_req_i     in   1   EXE_down slot presents an MDU op (younger slot)
//  down_op_i      in   3   as up_op_i
//  down_src0_i    in   32  rs value
//  down_src1_i    in   32  rt value
//  up_ready_o     out  1   up op accepted this cycle when up_req_i=1
//  down_ready_o   out  1   down op accepted this cycle when down_req_i=1
//  commit_i       in   1   the in-flight MDU op retired at SBA
//  flush_i        in   1   SBA_flush | CP0_excOccur
//  nonBlockMark_o out  1   MDU op in flight; HI/LO not yet final
//  hi_o           out  32  architectural HI
//  lo_o           out  32  architectural LO
// BEHAVIOUR
//  Reset: state=IDLE, hi_o=lo_o=0, nonBlockMark_o=0, committed=0, counter=0. Ready outputs follow the equations below.
//  Ready:
//   - up_ready_o   = (state==IDLE).
//   - down_ready_o = (state==IDLE) && !up_req_i. The up slot wins on simultaneous requests (program order).
//  Accept (req&&ready): latch op and operands, set committed=0. Next state:
//   - MUL for MULT/MULTU
//   - DIV for DIV/DIVU
//   - HOLD for MTHI/MTLO; result = src0, zero compute latency.
//  FSM:
//   - IDLE -> MUL | DIV | HOLD on accept.
//   - MUL: counter 0..MUL_STAGES-1; at last count -> HOLD with {hi,lo} = 64-bit product. MULT is signed, MULTU unsigned.
//   - DIV: counter 0..DIV_CYCLES-1; at last count -> HOLD with lo=quotient, hi=remainder.
//     Signed DIV: quotient sign = src0^src1; remainder sign = src0.
//     Divide by zero: lo=32'hFFFF_FFFF, hi=src0; no exception.
//   - HOLD: wait for commit, then write HI/LO and -> IDLE. MTHI writes hi only; MTLO writes lo only.
//  Commit:
//   - committed is set by commit_i in any non-IDLE state.
//   - If commit_i arrives in HOLD, or committed=1 on entry to HOLD, HI/LO are written that same edge and state -> IDLE.
//   - Commit before result-ready is legal; the op keeps running.
//  Flush:
//   - flush_i with committed=0 and commit_i=0 aborts the op: -> IDLE next edge, HI/LO unchanged, counter cleared.
//   - flush_i with committed=1 is ignored; the op belongs to a retired instruction.
//   - flush_i and commit_i in the same cycle: commit wins. The flush targets younger instructions.
//   - flush_i in IDLE: no effect. A req accepted in the same cycle as flush_i is discarded and state stays IDLE.
//  nonBlockMark_o = (state!=IDLE). It deasserts the cycle after HI/LO are written, so the first MFHI then reads the new value.
//  hi_o/lo_o change only on a committed write or on reset.
//  No new op is accepted in the cycle HI/LO are written; ready rises the next cycle.
//  Async reset mid-operation: all state returns to reset values immediately; the partial result is lost.
// STRUCTURE
//  Shared package / MyDefines.v:
//   - `MDU_OP encodings
//   - state encoding `MDU_IDLE/`MDU_MUL/`MDU_DIV/`MDU_HOLD
//   - `MDU_OP_LEN
//  Sub-module mdu_div_iter: radix-2 restoring divider.
//   - Ports: start, signed, dividend, divisor, abort; outputs done, quot, rem.
//   - Takes absolute values in the setup cycle and fixes signs on done.
//  The multiplier stays inline as a `*` followed by a MUL_STAGES-deep register chain, retimable by synthesis.
// TESTING
//  1. up MULT src0=-3, src1=7, commit_i 1 cycle later -> nonBlockMark_o high for MUL_STAGES+1 cycles; hi=FFFF_FFFF, lo=FFFF_FFEB.
//  2. up DIVU 100/7 and down MTLO same cycle -> up_ready_o=1, down_ready_o=0. Commit -> hi=2, lo=14. down accepted on the first IDLE cycle.
//  3. DIV src0=-7, src1=2, flush_i at cycle 10 with no commit -> state IDLE next cycle; hi/lo unchanged; nonBlockMark_o=0.
//  4. DIV 5/0, commit_i and flush_i together at cycle 3 -> op completes after DIV_CYCLES; lo=FFFF_FFFF, hi=5.
//  5. MTHI src0=0xDEAD_BEEF, commit in same cycle HOLD is entered -> hi_o=DEAD_BEEF next edge, lo unchanged; ready high one cycle later.
//  6. rst pulsed mid-DIV (async, between clock edges) -> hi/lo=0, state IDLE, ready high immediately after rst falls.

Source files
------------

// File: rtl/mdu_issue_ctrl_pkg.sv
// Shared encodings for the multiply/divide issue controller: op codes, FSM states
// and small op-classification helpers.
package mdu_issue_ctrl_pkg;

    localparam int MDU_OP_LEN = 3;

    typedef enum logic [MDU_OP_LEN-1:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } mdu_op_e;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_MUL  = 2'd1,
        MDU_DIV  = 2'd2,
        MDU_HOLD = 2'd3
    } mdu_state_e;

    function automatic logic op_is_mul(input mdu_op_e op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

    function automatic logic op_is_div(input mdu_op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input mdu_op_e op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/mdu_issue_ctrl_div_iter.sv
// Radix-2 restoring divider: one setup edge on start, then 32 iterations on
// magnitudes; signs and the divide-by-zero result are applied at the outputs.
module mdu_div_iter (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        signed_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    input  logic        abort_i,
    output logic        done_o,
    output logic [31:0] quot_o,
    output logic [31:0] rem_o
);
    logic        busy_q, done_q;
    logic [4:0]  iter_q;
    logic [31:0] rem_q, quo_q, dvs_q, dvd_q;
    logic        negq_q, negr_q, dz_q;
    logic [31:0] abs_dvd, abs_dvs;
    logic [32:0] shifted, diff;

    always_comb begin
        abs_dvd = (signed_i && dividend_i[31]) ? -dividend_i : dividend_i;
        abs_dvs = (signed_i && divisor_i[31])  ? -divisor_i  : divisor_i;
        shifted = {rem_q, quo_q[31]};
        diff    = shifted - {1'b0, dvs_q};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            iter_q <= '0;
        end else if (abort_i) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            iter_q <= '0;
        end else if (start_i) begin
            busy_q <= 1'b1;
            done_q <= 1'b0;
            iter_q <= '0;
        end else if (busy_q) begin
            iter_q <= iter_q + 5'd1;
            if (iter_q == 5'd31) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end
        end
    end

    // A borrow out of the 33-bit trial subtraction means the divisor did not fit.
    always_ff @(posedge clk) begin
        if (start_i) begin
            rem_q  <= '0;
            quo_q  <= abs_dvd;
            dvs_q  <= abs_dvs;
            dvd_q  <= dividend_i;
            negq_q <= signed_i && (dividend_i[31] ^ divisor_i[31]);
            negr_q <= signed_i && dividend_i[31];
            dz_q   <= (divisor_i == 32'd0);
        end else if (busy_q) begin
            if (!diff[32]) begin
                rem_q <= diff[31:0];
                quo_q <= {quo_q[30:0], 1'b1};
            end else begin
                rem_q <= shifted[31:0];
                quo_q <= {quo_q[30:0], 1'b0};
            end
        end
    end

    assign done_o = done_q;
    assign quot_o = dz_q ? 32'hFFFF_FFFF : (negq_q ? -quo_q : quo_q);
    assign rem_o  = dz_q ? dvd_q : (negr_q ? -rem_q : rem_q);

endmodule

// File: rtl/mdu_issue_ctrl.sv
// HI/LO owner that shares one multiply/divide unit between the two EXE issue slots;
// results wait in HOLD until the op retires, and flushes abort uncommitted ops.
module mdu_issue_ctrl
    import mdu_issue_ctrl_pkg::*;
#(
    parameter int MUL_STAGES = 2,
    parameter int DIV_CYCLES = 33
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        up_req_i,
    input  logic [2:0]  up_op_i,
    input  logic [31:0] up_src0_i,
    input  logic [31:0] up_src1_i,
    input  logic        down_req_i,
    input  logic [2:0]  down_op_i,
    input  logic [31:0] down_src0_i,
    input  logic [31:0] down_src1_i,
    output logic        up_ready_o,
    output logic        down_ready_o,
    input  logic        commit_i,
    input  logic        flush_i,
    output logic        nonBlockMark_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);
    localparam int CNT_MAX = (MUL_STAGES > DIV_CYCLES) ? MUL_STAGES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_STAGES - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_CYCLES - 1);

    mdu_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             committed_q;
    logic [31:0]      hi_q, lo_q;
    mdu_op_e          op_q;
    logic [31:0]      src0_q, src1_q, res_hi_q, res_lo_q;

    logic        accept, kill;
    mdu_op_e     acc_op;
    logic [31:0] acc_src0, acc_src1;
    logic [63:0] mul_a, mul_b, mul_prod, mul_res;
    logic        div_done;
    logic [31:0] div_quot, div_rem;

    always_comb begin
        up_ready_o   = (state_q == MDU_IDLE);
        down_ready_o = up_ready_o && !up_req_i;
        accept   = ((up_req_i && up_ready_o) || (down_req_i && down_ready_o)) && !flush_i;
        acc_op   = up_req_i ? mdu_op_e'(up_op_i) : mdu_op_e'(down_op_i);
        acc_src0 = up_req_i ? up_src0_i : down_src0_i;
        acc_src1 = up_req_i ? up_src1_i : down_src1_i;
        kill     = (state_q != MDU_IDLE) && flush_i && !committed_q && !commit_i;
        mul_a    = {{32{op_is_signed(op_q) & src0_q[31]}}, src0_q};
        mul_b    = {{32{op_is_signed(op_q) & src1_q[31]}}, src1_q};
        mul_prod = mul_a * mul_b;
    end

    // Product register chain; the last stage is the result register itself.
    generate
        if (MUL_STAGES == 1) begin : g_mul_comb
            assign mul_res = mul_prod;
        end else begin : g_mul_pipe
            logic [63:0] pipe_q [MUL_STAGES-1];
            always_ff @(posedge clk) begin
                pipe_q[0] <= mul_prod;
                for (int i = 1; i < MUL_STAGES - 1; i++) pipe_q[i] <= pipe_q[i-1];
            end
            assign mul_res = pipe_q[MUL_STAGES-2];
        end
    endgenerate

    mdu_div_iter u_div (
        .clk        (clk),
        .rst        (rst),
        .start_i    (accept && op_is_div(acc_op)),
        .signed_i   (acc_op == OP_DIV),
        .dividend_i (acc_src0),
        .divisor_i  (acc_src1),
        .abort_i    (kill),
        .done_o     (div_done),
        .quot_o     (div_quot),
        .rem_o      (div_rem)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= MDU_IDLE;
            cnt_q       <= '0;
            committed_q <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
        end else begin
            case (state_q)
                MDU_IDLE: begin
                    cnt_q       <= '0;
                    committed_q <= 1'b0;
                    if (accept)
                        state_q <= op_is_mul(acc_op) ? MDU_MUL :
                                   op_is_div(acc_op) ? MDU_DIV : MDU_HOLD;
                end
                default: begin
                    if (commit_i) committed_q <= 1'b1;
                    if (kill) begin
                        state_q     <= MDU_IDLE;
                        cnt_q       <= '0;
                        committed_q <= 1'b0;
                    end else begin
                        case (state_q)
                            MDU_MUL: begin
                                if (cnt_q == MUL_LAST) begin
                                    state_q <= MDU_HOLD;
                                    cnt_q   <= '0;
                                end else cnt_q <= cnt_q + 1'b1;
                            end
                            MDU_DIV: begin
                                if (cnt_q == DIV_LAST && div_done) begin
                                    state_q <= MDU_HOLD;
                                    cnt_q   <= '0;
                                end else if (cnt_q != DIV_LAST) cnt_q <= cnt_q + 1'b1;
                            end
                            MDU_HOLD: begin
                                if (commit_i || committed_q) begin
                                    if (op_q != OP_MTLO) hi_q <= res_hi_q;
                                    if (op_q != OP_MTHI) lo_q <= res_lo_q;
                                    state_q     <= MDU_IDLE;
                                    committed_q <= 1'b0;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            op_q     <= acc_op;
            src0_q   <= acc_src0;
            src1_q   <= acc_src1;
            res_hi_q <= acc_src0;
            res_lo_q <= acc_src0;
        end else if (state_q == MDU_MUL && cnt_q == MUL_LAST) begin
            {res_hi_q, res_lo_q} <= mul_res;
        end else if (state_q == MDU_DIV && cnt_q == DIV_LAST) begin
            res_hi_q <= div_rem;
            res_lo_q <= div_quot;
        end
    end

    assign nonBlockMark_o = (state_q != MDU_IDLE);
    assign hi_o           = hi_q;
    assign lo_o           = lo_q;

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Bench for mdu_issue_ctrl: directed scenarios plus random traffic, compared each
// cycle against a countdown/arithmetic model of the MDU issue rules.
module tb_mdu_issue_ctrl;
    import mdu_issue_ctrl_pkg::*;

    localparam int MUL_STAGES = 2;
    localparam int DIV_CYCLES = 33;

    logic        clk, rst;
    logic        up_req, down_req, commit, flush;
    logic [2:0]  up_op, down_op;
    logic [31:0] up_s0, up_s1, dn_s0, dn_s1;
    logic        up_ready, down_ready, nbm;
    logic [31:0] hi, lo;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: busy flag, cycles left before the result is ready, commit flag.
    bit          m_busy = 0, m_cmt = 0, m_wh = 0, m_wl = 0;
    int          m_left = 0;
    logic [31:0] m_hi = 0, m_lo = 0, m_rhi = 0, m_rlo = 0;

    mdu_issue_ctrl #(.MUL_STAGES(MUL_STAGES), .DIV_CYCLES(DIV_CYCLES)) dut (
        .clk(clk), .rst(rst),
        .up_req_i(up_req), .up_op_i(up_op), .up_src0_i(up_s0), .up_src1_i(up_s1),
        .down_req_i(down_req), .down_op_i(down_op), .down_src0_i(dn_s0), .down_src1_i(dn_s1),
        .up_ready_o(up_ready), .down_ready_o(down_ready),
        .commit_i(commit), .flush_i(flush),
        .nonBlockMark_o(nbm), .hi_o(hi), .lo_o(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic model_accept(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        longint      sq, sr;
        m_busy = 1; m_cmt = 0; m_wh = 1; m_wl = 1;
        case (op)
            OP_MULT, OP_MULTU: begin
                if (op == OP_MULT) p = longint'($signed(a)) * longint'($signed(b));
                else               p = {32'b0, a} * {32'b0, b};
                m_rhi = p[63:32]; m_rlo = p[31:0]; m_left = MUL_STAGES;
            end
            OP_DIV, OP_DIVU: begin
                m_left = DIV_CYCLES;
                if (b == 32'd0) begin
                    m_rlo = 32'hFFFF_FFFF; m_rhi = a;
                end else begin
                    if (op == OP_DIV) begin
                        sq = longint'($signed(a)) / longint'($signed(b));
                        sr = longint'($signed(a)) % longint'($signed(b));
                    end else begin
                        sq = longint'({32'b0, a}) / longint'({32'b0, b});
                        sr = longint'({32'b0, a}) % longint'({32'b0, b});
                    end
                    m_rlo = sq[31:0]; m_rhi = sr[31:0];
                end
            end
            OP_MTHI: begin m_left = 0; m_rhi = a; m_rlo = a; m_wl = 0; end
            default: begin m_left = 0; m_rhi = a; m_rlo = a; m_wh = 0; end
        endcase
    endtask

    task automatic step(input logic ur, input logic [2:0] uo, input logic [31:0] ua, input logic [31:0] ub,
                        input logic dr, input logic [2:0] dop, input logic [31:0] da, input logic [31:0] db,
                        input logic cm, input logic fl);
        bit k;
        @(posedge clk); #1;
        up_req = ur; up_op = uo; up_s0 = ua; up_s1 = ub;
        down_req = dr; down_op = dop; dn_s0 = da; dn_s1 = db;
        commit = cm; flush = fl;
        @(negedge clk);
        chk("up_ready", {31'b0, up_ready}, {31'b0, !m_busy});
        chk("down_ready", {31'b0, down_ready}, {31'b0, !m_busy && !ur});
        chk("nonBlockMark", {31'b0, nbm}, {31'b0, m_busy});
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
        if (!m_busy) begin
            if (!fl && ur)      model_accept(uo, ua, ub);
            else if (!fl && dr) model_accept(dop, da, db);
        end else begin
            k = fl && !m_cmt && !cm;
            if (cm) m_cmt = 1;
            if (k) m_busy = 0;
            else if (m_left > 0) m_left--;
            else if (m_cmt) begin
                if (m_wh) m_hi = m_rhi;
                if (m_wl) m_lo = m_rlo;
                m_busy = 0;
            end
        end
    endtask

    task automatic idle(input logic cm);
        step(0, 3'd0, 0, 0, 0, 3'd0, 0, 0, cm, 0);
    endtask

    task automatic drain(input logic cm);
        for (int i = 0; i < 100 && m_busy; i++) idle(cm);
        idle(0);
    endtask

    initial begin
        logic [31:0] a, b, c, d;
        logic [2:0]  o1, o2;
        rst = 1'b1;
        up_req = 0; up_op = 0; up_s0 = 0; up_s1 = 0;
        down_req = 0; down_op = 0; dn_s0 = 0; dn_s1 = 0;
        commit = 0; flush = 0;
        #12 rst = 1'b0;

        idle(0);

        // MULT -3 * 7 with an early commit
        step(1, OP_MULT, 32'hFFFF_FFFD, 32'd7, 0, 3'd0, 0, 0, 0, 0);
        idle(1);
        drain(0);
        chk("t1_hi", hi, 32'hFFFF_FFFF);
        chk("t1_lo", lo, 32'hFFFF_FFEB);

        // DIVU 100/7 beats a simultaneous MTLO from the down slot
        step(1, OP_DIVU, 32'd100, 32'd7, 1, OP_MTLO, 32'h0000_1234, 0, 0, 0);
        for (int i = 0; i < 100 && m_busy; i++)
            step(0, 3'd0, 0, 0, 1, OP_MTLO, 32'h0000_1234, 0, (i == 0), 0);
        step(0, 3'd0, 0, 0, 1, OP_MTLO, 32'h0000_1234, 0, 0, 0);
        chk("t2_hi", hi, 32'd2);
        chk("t2_lo", lo, 32'd14);
        drain(1);
        chk("t2_mtlo", lo, 32'h0000_1234);

        // DIV -7/2 flushed before commit
        step(1, OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, 3'd0, 0, 0, 0, 0);
        repeat (9) idle(0);
        step(0, 3'd0, 0, 0, 0, 3'd0, 0, 0, 0, 1);
        idle(0);
        chk("t3_nbm", {31'b0, nbm}, 32'd0);
        chk("t3_hi", hi, 32'd2);
        chk("t3_lo", lo, 32'h0000_1234);

        // DIV 5/0 with commit and flush together
        step(1, OP_DIV, 32'd5, 32'd0, 0, 3'd0, 0, 0, 0, 0);
        idle(0); idle(0);
        step(0, 3'd0, 0, 0, 0, 3'd0, 0, 0, 1, 1);
        drain(0);
        chk("t4_lo", lo, 32'hFFFF_FFFF);
        chk("t4_hi", hi, 32'd5);

        // MTHI committed in its HOLD cycle
        step(1, OP_MTHI, 32'hDEAD_BEEF, 0, 0, 3'd0, 0, 0, 0, 0);
        idle(1);
        idle(0);
        chk("t5_hi", hi, 32'hDEAD_BEEF);
        chk("t5_lo", lo, 32'hFFFF_FFFF);
        chk("t5_rdy", {31'b0, up_ready}, 32'd1);

        // asynchronous reset mid-divide
        step(1, OP_DIVU, 32'd50, 32'd3, 0, 3'd0, 0, 0, 1, 0);
        repeat (5) idle(0);
        #1 rst = 1'b1;
        #1;
        chk("t6_nbm", {31'b0, nbm}, 32'd0);
        chk("t6_hi", hi, 32'd0);
        chk("t6_lo", lo, 32'd0);
        rst = 1'b0;
        #1;
        chk("t6_rdy", {31'b0, up_ready}, 32'd1);
        m_busy = 0; m_cmt = 0; m_hi = 0; m_lo = 0;
        idle(0);

        for (int n = 0; n < 2500; n++) begin
            a  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 300) : $urandom;
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 :
                 ($urandom_range(0, 2) == 0) ? $urandom_range(1, 40) : $urandom;
            c  = $urandom;
            d  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            o1 = 3'($urandom_range(0, 5));
            o2 = 3'($urandom_range(0, 5));
            step($urandom_range(0, 3) == 0, o1, a, b, $urandom_range(0, 3) == 0, o2, c, d,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 11) == 0);
        end
        drain(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
